// File: rtl/nexus_bucket_pop_ctrl.sv
// Per-bucket occupancy tracker driving an external priority bitset; pops the lowest non-empty bucket.
// Pop latency: request -> o_pop_valid two cycles later; pushes stall only during the one-cycle UPDATE.
module nexus_bucket_pop_ctrl #(
  parameter  int BUCKETS = 256,
  parameter  int CNT_W   = 8,
  parameter  int TOT_W   = 16,
  localparam int IW      = (BUCKETS > 1) ? $clog2(BUCKETS) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_push_valid,
  input  logic [IW-1:0]    i_push_bucket,
  output logic             o_push_ready,
  output logic             o_bs_set_valid,
  output logic             o_bs_clear_valid,
  output logic [IW-1:0]    o_bs_bucket_idx,
  input  logic             i_bs_valid,
  input  logic [IW-1:0]    i_bs_best_idx,
  input  logic             i_pop_req,
  output logic             o_pop_valid,
  output logic [IW-1:0]    o_pop_bucket,
  input  logic             i_pop_ready,
  output logic             o_pop_empty,
  output logic [TOT_W-1:0] o_total
);

  typedef enum logic [1:0] {IDLE, LOOKUP, PRESENT, UPDATE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [BUCKETS];
  logic [CNT_W-1:0] cnt_d [BUCKETS];
  logic [TOT_W-1:0] total_q, total_d;
  logic [IW-1:0]    pop_bucket_q, pop_bucket_d;
  logic             pop_empty_q, pop_empty_d;
  logic             push_acc;
  logic             pop_last;

  // Gated by reset so no set strobe can leak out while the block is held in reset.
  assign o_push_ready = i_arst_n
                     && (state_q != UPDATE)
                     && (cnt_q[i_push_bucket] != CNT_MAX)
                     && (total_q != TOT_MAX);
  assign push_acc     = i_push_valid && o_push_ready;
  assign pop_last     = (state_q == UPDATE) && (cnt_q[pop_bucket_q] == CNT_ONE);

  assign o_bs_set_valid   = push_acc;
  assign o_bs_clear_valid = pop_last;
  assign o_bs_bucket_idx  = push_acc ? i_push_bucket :
                            pop_last ? pop_bucket_q  : '0;
  assign o_pop_valid      = (state_q == PRESENT);
  assign o_pop_bucket     = pop_bucket_q;
  assign o_pop_empty      = pop_empty_q;
  assign o_total          = total_q;

  always_comb begin
    state_d      = state_q;
    pop_bucket_d = pop_bucket_q;
    pop_empty_d  = 1'b0;
    total_d      = total_q;
    cnt_d        = cnt_q;

    if (push_acc) begin
      cnt_d[i_push_bucket] = cnt_q[i_push_bucket] + CNT_ONE;
      total_d              = total_q + TOT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_pop_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (i_bs_valid) begin
          pop_bucket_d = i_bs_best_idx;
          state_d      = PRESENT;
        end else begin
          pop_empty_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      PRESENT: begin
        if (i_pop_ready) state_d = UPDATE;
      end
      UPDATE: begin
        // Pushes are blocked here, so this is the only counter write this cycle.
        cnt_d[pop_bucket_q] = cnt_q[pop_bucket_q] - CNT_ONE;
        total_d             = total_q - TOT_W'(1);
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= IDLE;
      total_q      <= '0;
      pop_bucket_q <= '0;
      pop_empty_q  <= 1'b0;
      for (int b = 0; b < BUCKETS; b++) cnt_q[b] <= '0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      pop_bucket_q <= pop_bucket_d;
      pop_empty_q  <= pop_empty_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nexus_bucket_pop_ctrl.sv
// Bench for nexus_bucket_pop_ctrl: directed scenarios plus random traffic against a count-based model.
// The bench plays the bitset macro, reporting the lowest bucket the model believes is non-empty.
module tb_nexus_bucket_pop_ctrl;

  logic        i_clk;
  logic        i_arst_n;
  logic        i_push_valid;
  logic [7:0]  i_push_bucket;
  logic        o_push_ready;
  logic        o_bs_set_valid;
  logic        o_bs_clear_valid;
  logic [7:0]  o_bs_bucket_idx;
  logic        i_bs_valid;
  logic [7:0]  i_bs_best_idx;
  logic        i_pop_req;
  logic        o_pop_valid;
  logic [7:0]  o_pop_bucket;
  logic        i_pop_ready;
  logic        o_pop_empty;
  logic [15:0] o_total;

  nexus_bucket_pop_ctrl #(.BUCKETS(256), .CNT_W(8), .TOT_W(16)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_push_valid(i_push_valid), .i_push_bucket(i_push_bucket), .o_push_ready(o_push_ready),
    .o_bs_set_valid(o_bs_set_valid), .o_bs_clear_valid(o_bs_clear_valid),
    .o_bs_bucket_idx(o_bs_bucket_idx),
    .i_bs_valid(i_bs_valid), .i_bs_best_idx(i_bs_best_idx),
    .i_pop_req(i_pop_req), .o_pop_valid(o_pop_valid), .o_pop_bucket(o_pop_bucket),
    .i_pop_ready(i_pop_ready), .o_pop_empty(o_pop_empty), .o_total(o_total)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy per bucket, total, and where the single pop in flight stands.
  localparam int PH_IDLE = 0, PH_LOOK = 1, PH_SHOW = 2, PH_DONE = 3;
  int m_cnt [256];
  int m_total;
  int m_phase;
  int m_pop_bkt;
  int m_empty;
  int m_bs_valid;
  int m_bs_idx;
  int m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 256; b++) m_cnt[b] = 0;
    m_total = 0; m_phase = PH_IDLE; m_pop_bkt = 0; m_empty = 0;
  endtask

  // Called at the negedge with inputs set; checks one cycle and advances the model across the edge.
  task automatic step();
    int exp_rdy, exp_set, exp_clr, exp_idx;
    m_bs_valid = 0; m_bs_idx = 0;
    for (int b = 255; b >= 0; b--) if (m_cnt[b] > 0) begin m_bs_valid = 1; m_bs_idx = b; end
    i_bs_valid    = m_bs_valid[0];
    i_bs_best_idx = 8'(m_bs_idx);
    #1;
    exp_rdy = (m_phase != PH_DONE) && (m_cnt[i_push_bucket] < 255) && (m_total < 65535);
    exp_set = i_push_valid && exp_rdy;
    exp_clr = (m_phase == PH_DONE) && (m_cnt[m_pop_bkt] == 1);
    exp_idx = exp_set ? int'(i_push_bucket) : (exp_clr ? m_pop_bkt : 0);
    chk("push_ready", 32'(o_push_ready), 32'(exp_rdy));
    chk("bs_set",     32'(o_bs_set_valid), 32'(exp_set));
    chk("bs_clear",   32'(o_bs_clear_valid), 32'(exp_clr));
    chk("bs_idx",     32'(o_bs_bucket_idx), 32'(exp_idx));
    chk("set_clr_excl", 32'(o_bs_set_valid & o_bs_clear_valid), 32'd0);
    chk("pop_valid",  32'(o_pop_valid), 32'(m_phase == PH_SHOW));
    chk("pop_bucket", 32'(o_pop_bucket), 32'(m_pop_bkt));
    chk("pop_empty",  32'(o_pop_empty), 32'(m_empty));
    chk("total",      32'(o_total), 32'(m_total));
    m_acc = exp_set;
    @(posedge i_clk);
    m_empty = 0;
    if (m_acc != 0) begin m_cnt[i_push_bucket]++; m_total++; end
    case (m_phase)
      PH_IDLE: if (i_pop_req) m_phase = PH_LOOK;
      PH_LOOK: if (m_bs_valid != 0) begin m_pop_bkt = m_bs_idx; m_phase = PH_SHOW; end
               else begin m_empty = 1; m_phase = PH_IDLE; end
      PH_SHOW: if (i_pop_ready) m_phase = PH_DONE;
      default: begin m_cnt[m_pop_bkt]--; m_total--; m_phase = PH_IDLE; end
    endcase
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_push_valid = 1'b1; i_push_bucket = 8'd1; i_pop_req = 1'b1; i_pop_ready = 1'b1;
    i_arst_n = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(o_pop_valid), 32'd0);
    chk("rst_pop_empty", 32'(o_pop_empty), 32'd0);
    chk("rst_set",       32'(o_bs_set_valid), 32'd0);
    chk("rst_clear",     32'(o_bs_clear_valid), 32'd0);
    chk("rst_idx",       32'(o_bs_bucket_idx), 32'd0);
    chk("rst_pop_bkt",   32'(o_pop_bucket), 32'd0);
    chk("rst_total",     32'(o_total), 32'd0);
    model_reset();
    @(negedge i_clk);
    i_arst_n = 1'b1;
    i_push_valid = 1'b0; i_pop_req = 1'b0; i_pop_ready = 1'b0;
  endtask

  // Full pop with consumer ready; returns the bucket the DUT presented and whether it signalled empty.
  task automatic do_pop(output logic [7:0] got, output logic saw_empty);
    got = 8'hxx; saw_empty = 1'b0;
    i_pop_req = 1'b1; i_pop_ready = 1'b1;
    step();
    i_pop_req = 1'b0;
    for (int k = 0; k < 8 && m_phase != PH_IDLE; k++) begin
      if (o_pop_valid) got = o_pop_bucket;
      step();
    end
    if (o_pop_empty) saw_empty = 1'b1;
    chk("pop_done", 32'(m_phase), 32'(PH_IDLE));
  endtask

  task automatic push(input int b);
    i_push_valid = 1'b1; i_push_bucket = 8'(b);
    step();
    i_push_valid = 1'b0;
  endtask

  logic [7:0] got;
  logic       emp;

  initial begin
    i_arst_n = 1'b0; i_push_valid = 1'b0; i_push_bucket = '0; i_pop_req = 1'b0;
    i_pop_ready = 1'b0; i_bs_valid = 1'b0; i_bs_best_idx = '0;
    model_reset();
    @(negedge i_clk);
    apply_reset();

    // Pop with nothing held: empty pulse two cycles after the request, never valid.
    do_pop(got, emp);
    chk("empty_pulse", 32'(emp), 32'd1);
    step();

    // Lowest index first; bucket 5 is cleared only when its second entry leaves.
    push(37); push(5); push(5);
    chk("total_3", 32'(o_total), 32'd3);
    do_pop(got, emp); chk("pop1_bkt", 32'(got), 32'd5);
    do_pop(got, emp); chk("pop2_bkt", 32'(got), 32'd5);
    do_pop(got, emp); chk("pop3_bkt", 32'(got), 32'd37);
    chk("total_0", 32'(o_total), 32'd0);

    // Stall in PRESENT while a better bucket arrives; the presented bucket must not move.
    push(7);
    i_pop_req = 1'b1; i_pop_ready = 1'b0; step();
    i_pop_req = 1'b0; step();
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin i_push_valid = 1'b1; i_push_bucket = 8'd2; end
      step();
      i_push_valid = 1'b0;
    end
    chk("stall_bkt", 32'(o_pop_bucket), 32'd7);
    i_pop_ready = 1'b1; step(); step();
    do_pop(got, emp); chk("stall_next_bkt", 32'(got), 32'd2);

    // Push held through a pop so it collides with the decrement cycle and waits one cycle.
    push(20);
    i_push_valid = 1'b1; i_push_bucket = 8'd21;
    i_pop_req = 1'b1; i_pop_ready = 1'b1; step();
    i_pop_req = 1'b0; i_push_valid = 1'b0; step(); step();
    i_push_valid = 1'b1; i_push_bucket = 8'd22;
    chk("upd_blocks_push", 32'(o_push_ready), 32'd0);
    step();
    chk("after_upd_ready", 32'(o_push_ready), 32'd1);
    step();
    i_push_valid = 1'b0;

    // Saturate bucket 9: only that bucket stops accepting.
    apply_reset();
    for (int k = 0; k < 255; k++) push(9);
    i_push_valid = 1'b1; i_push_bucket = 8'd9; #1;
    chk("sat_9_ready", 32'(o_push_ready), 32'd0);
    step();
    i_push_bucket = 8'd10; #1;
    chk("sat_10_ready", 32'(o_push_ready), 32'd1);
    step();
    i_push_valid = 1'b0;
    chk("sat_total", 32'(o_total), 32'd256);

    // Reset landing while a bucket is presented discards everything.
    apply_reset();
    push(4);
    i_pop_req = 1'b1; i_pop_ready = 1'b0; step();
    i_pop_req = 1'b0; step();
    chk("pre_rst_valid", 32'(o_pop_valid), 32'd1);
    apply_reset();
    do_pop(got, emp);
    chk("post_rst_empty", 32'(emp), 32'd1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      i_push_valid  = ($urandom_range(0, 1) == 1);
      i_push_bucket = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 15));
      i_pop_req     = ($urandom_range(0, 2) == 0);
      i_pop_ready   = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nexus_bucket_pop_ctrl.md
NEXUS_BUCKET_POP_CTRL -- requirements
Module: nexus_bucket_pop_ctrl

Interface
REQ-001 SHALL have parameter BUCKETS, default 256: number of buckets; bucket index width IW = clog2(BUCKETS) = 8.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-bucket occupancy counter.
REQ-003 SHALL have parameter TOT_W, default 16: width of the total occupancy counter.
REQ-004 SHALL have port i_clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port i_arst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_push_valid, input, 1, push request.
REQ-007 SHALL have port i_push_bucket, input, IW, bucket to push into.
REQ-008 SHALL have port o_push_ready, output, 1, push accepted when high together with i_push_valid.
REQ-009 SHALL have port o_bs_set_valid, output, 1, set strobe to the macro bitset.
REQ-010 SHALL have port o_bs_clear_valid, output, 1, clear strobe to the macro bitset.
REQ-011 SHALL have port o_bs_bucket_idx, output, IW, bucket index for the set/clear strobe.
REQ-012 SHALL have port i_bs_valid, input, 1, bitset reports at least one non-empty bucket.
REQ-013 SHALL have port i_bs_best_idx, input, IW, lowest-index non-empty bucket from the bitset.
REQ-014 SHALL have port i_pop_req, input, 1, request one dequeue.
REQ-015 SHALL have port o_pop_valid, output, 1, popped bucket is presented.
REQ-016 SHALL have port o_pop_bucket, output, IW, popped bucket index.
REQ-017 SHALL have port i_pop_ready, input, 1, consumer accepts o_pop_bucket.
REQ-018 SHALL have port o_pop_empty, output, 1, one-cycle pulse when a pop finds no entry.
REQ-019 SHALL have port o_total, output, TOT_W, total entries held.

Function
REQ-020 SHALL keep CNT_W-bit counter cnt[b] for each bucket and FSM states IDLE, LOOKUP, PRESENT, UPDATE.
REQ-021 SHALL drive o_push_ready = (state != UPDATE) and (cnt[i_push_bucket] != 2^CNT_W-1) and (o_total != 2^TOT_W-1), combinationally.
REQ-022 SHALL, on push accept: increment cnt[i_push_bucket] and o_total next edge; assert o_bs_set_valid with o_bs_bucket_idx = i_push_bucket in the same cycle (combinational).
REQ-023 SHALL transition IDLE -> LOOKUP when i_pop_req=1; i_pop_req ignored in other states.
REQ-024 SHALL, in LOOKUP: if i_bs_valid, register o_pop_bucket = i_bs_best_idx and go PRESENT; else pulse o_pop_empty for the next cycle and go IDLE.
REQ-025 SHALL hold o_pop_valid=1 and o_pop_bucket stable throughout PRESENT; a better bucket pushed during PRESENT does not change o_pop_bucket.
REQ-026 SHALL go PRESENT -> UPDATE on the cycle o_pop_valid and i_pop_ready are both high; o_pop_valid drops the following cycle.
REQ-027 SHALL, in UPDATE: decrement cnt[o_pop_bucket] and o_total; if cnt[o_pop_bucket]==1, assert o_bs_clear_valid with o_bs_bucket_idx = o_pop_bucket for that cycle; go IDLE.
REQ-028 SHALL never assert o_bs_set_valid and o_bs_clear_valid in the same cycle (pushes blocked in UPDATE).
REQ-029 SHALL allow pushes in IDLE, LOOKUP and PRESENT, including into o_pop_bucket; counter reads in UPDATE see those increments.
REQ-030 SHALL give minimum pop latency: i_pop_req at cycle N -> o_pop_valid at N+2; back-to-back pops every 4 cycles with i_pop_ready held high.
REQ-031 SHALL drive o_bs_bucket_idx = 0 when neither strobe is asserted.

Reset
REQ-032 SHALL on i_arst_n low asynchronously clear all cnt[b], o_total, o_pop_bucket to 0, state to IDLE; o_pop_valid, o_pop_empty, o_bs_set_valid, o_bs_clear_valid = 0.
REQ-033 SHALL abandon any pop in flight on reset mid-operation; no clear strobe is issued and the popped entry is lost with all others.
REQ-034 SHALL resume normal operation on the first rising edge after i_arst_n deasserts.

Verification
REQ-035 SHALL cover: pop in empty state -> o_pop_empty pulse 2 cycles after i_pop_req, o_pop_valid stays 0, o_total=0.
REQ-036 SHALL cover: push buckets 37, 5, 5 then pop x3 -> o_pop_bucket 5, 5, 37; clear strobe for 5 only on second pop, for 37 on third; o_total 3->0.
REQ-037 SHALL cover: i_pop_ready held low 10 cycles in PRESENT with push to bucket 2 mid-stall -> o_pop_bucket stays original value, cnt[2]=1, no clear of 2.
REQ-038 SHALL cover: 255 pushes to bucket 9 -> o_push_ready low for bucket 9 only; push to bucket 10 still accepted.
REQ-039 SHALL cover: push valid during UPDATE -> o_push_ready=0, accepted next cycle; set/clear never coincident.
REQ-040 SHALL cover: reset asserted in PRESENT -> all outputs 0 immediately, o_total=0, next pop gives o_pop_empty.
